// File: rtl/rtc_seq_ctrl_param.sv
// rtc_seq_ctrl_param
//   Master sequencer for RTC register traffic. Walks a fixed address list per
//   mode (init, continuous read, config read, write-back) and presents one
//   transaction at a time to the bus-transaction block below. It advances one
//   list step per in_done pulse.
//
//   Handshake: out_en/out_addr/out_wr/out_data_init describe the transaction
//   currently requested. The block below raises in_done for exactly one cycle
//   when it has finished that transaction. On the following cycle the outputs
//   already describe the next step. in_done is ignored while in IDLE.
//
//   Optional feature macro: RTC_SEQ_WDT_EN enables a done-watchdog. If no
//   in_done arrives within WDT_CYCLES cycles of the last done or state change,
//   out_timeout pulses and the sequence restarts from IDLE/INIT.
//   Without the macro, out_timeout is tied low.
module rtc_seq_ctrl_param #(
   parameter int                ADDR_W         = 8,
   parameter int                DATA_W         = 8,
   parameter int                NUM_TIME_REGS  = 7,
   parameter int                NUM_TIMER_REGS = 3,
   parameter logic [ADDR_W-1:0] TIME_BASE      = ADDR_W'(8'h21),
   parameter logic [ADDR_W-1:0] TIMER_BASE     = ADDR_W'(8'h41),
   parameter logic [ADDR_W-1:0] CMD_RD         = ADDR_W'(8'hF0),
   parameter logic [ADDR_W-1:0] CMD_TIME       = ADDR_W'(8'hF1),
   parameter logic [ADDR_W-1:0] CMD_TIMER      = ADDR_W'(8'hF2),
   parameter int                WDT_CYCLES     = 1024
) (
   input  logic              clk,
   input  logic              reset_count,
   input  logic              in_done,
   input  logic [2:0]        in_mode,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data_init,
   output logic              out_init,
   output logic              out_wr,
   output logic              out_en,
   output logic [2:0]        out_state,
   output logic [4:0]        out_step,
   output logic              out_timeout
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INIT      = 3'd1,
      S_RD_CTE    = 3'd2,
      S_CFG_TIME  = 3'd3,
      S_CFG_DATE  = 3'd4,
      S_CFG_TIMER = 3'd5,
      S_WR_TIME   = 3'd6,
      S_WR_TIMER  = 3'd7
   } state_t;

   localparam logic [4:0]        NT5   = 5'(NUM_TIME_REGS);
   localparam logic [4:0]        NR5   = 5'(NUM_TIMER_REGS);
   localparam logic [ADDR_W-1:0] NT_A  = ADDR_W'(NUM_TIME_REGS);
   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] FIVE_A = ADDR_W'(5);

   state_t            state;
   state_t            state_nxt;
   state_t            list_next;
   logic [4:0]        step;
   logic [4:0]        step_nxt;
   logic [4:0]        last_step;
   logic [ADDR_W-1:0] step_a;

   assign step_a = ADDR_W'(step);

   // Index of the final step of the current list
   always_comb begin
      last_step = 5'd0;
      case (state)
         S_INIT:      last_step = 5'd3;
         S_RD_CTE:    last_step = NT5 + NR5;
         S_CFG_TIME:  last_step = NR5;
         S_CFG_DATE:  last_step = NR5 + 5'd4;
         S_CFG_TIMER: last_step = NT5;
         S_WR_TIME:   last_step = NT5;
         S_WR_TIMER:  last_step = NR5;
         default:     last_step = 5'd0;
      endcase
   end

   // State entered when the current list completes; in_mode matters only here
   always_comb begin
      list_next = state;
      case (state)
         S_INIT:      list_next = S_RD_CTE;
         S_RD_CTE: begin
            case (in_mode)
               3'b001:  list_next = S_CFG_TIME;
               3'b010:  list_next = S_CFG_DATE;
               3'b100:  list_next = S_CFG_TIMER;
               default: list_next = S_RD_CTE;
            endcase
         end
         S_CFG_TIME,
         S_CFG_DATE:  list_next = (in_mode == 3'b000) ? S_WR_TIME  : state;
         S_CFG_TIMER: list_next = (in_mode == 3'b000) ? S_WR_TIMER : state;
         S_WR_TIME,
         S_WR_TIMER:  list_next = S_RD_CTE;
         default:     list_next = S_INIT;
      endcase
   end

   // Normal step/state advance; a list-end clears the step instead of incrementing
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      if (state == S_IDLE) begin
         state_nxt = S_INIT;
         step_nxt  = 5'd0;
      end else if (in_done) begin
         if (step == last_step) begin
            state_nxt = list_next;
            step_nxt  = 5'd0;
         end else begin
            step_nxt = step + 5'd1;
         end
      end
   end

`ifdef RTC_SEQ_WDT_EN
   localparam int               WDT_W    = $clog2(WDT_CYCLES) + 1;
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_cnt;
   logic             timeout_q;

   // Sequencer registers with watchdog; expiry forces a restart through IDLE
   always_ff @(posedge clk or posedge reset_count) begin
      if (reset_count) begin
         state     <= S_IDLE;
         step      <= 5'd0;
         wdt_cnt   <= '0;
         timeout_q <= 1'b0;
      end else if (state != S_IDLE && !in_done && wdt_cnt == WDT_LAST) begin
         state     <= S_IDLE;
         step      <= 5'd0;
         wdt_cnt   <= '0;
         timeout_q <= 1'b1;
      end else begin
         state     <= state_nxt;
         step      <= step_nxt;
         timeout_q <= 1'b0;
         if (in_done || state_nxt != state)
            wdt_cnt <= '0;
         else
            wdt_cnt <= wdt_cnt + 1'b1;
      end
   end

   assign out_timeout = timeout_q;
`else
   // Sequencer registers; waits indefinitely for in_done
   always_ff @(posedge clk or posedge reset_count) begin
      if (reset_count) begin
         state <= S_IDLE;
         step  <= 5'd0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
      end
   end

   assign out_timeout = 1'b0;
`endif

   // Transaction decode from state and step; IDLE (also the reset state) reads all zero
   always_comb begin
      out_addr      = '0;
      out_data_init = '0;
      out_init      = 1'b0;
      out_wr        = 1'b0;
      out_en        = (state != S_IDLE);
      case (state)
         S_INIT: begin
            out_init = 1'b1;
            out_wr   = 1'b1;
            case (step)
               5'd0:    begin out_addr = ADDR_W'(8'h02); out_data_init = DATA_W'(8'h10); end
               5'd1:    begin out_addr = ADDR_W'(8'h02); out_data_init = DATA_W'(8'h00); end
               5'd2:    begin out_addr = ADDR_W'(8'h10); out_data_init = DATA_W'(8'hD2); end
               default: begin out_addr = ADDR_W'(8'h00); out_data_init = DATA_W'(8'h00); end
            endcase
         end
         S_RD_CTE: begin
            if (step == 5'd0)      out_addr = CMD_RD;
            else if (step <= NT5)  out_addr = TIME_BASE + step_a - ONE_A;
            else                   out_addr = TIMER_BASE + step_a - ONE_A - NT_A;
         end
         S_CFG_TIME: begin
            if (step == 5'd0)      out_addr = CMD_TIMER;
            else                   out_addr = TIMER_BASE + step_a - ONE_A;
         end
         S_CFG_DATE: begin
            if (step == 5'd0)      out_addr = CMD_TIME;
            else if (step <= 5'd3) out_addr = TIME_BASE + step_a - ONE_A;
            else if (step == 5'd4) out_addr = CMD_TIMER;
            else                   out_addr = TIMER_BASE + step_a - FIVE_A;
         end
         S_CFG_TIMER: begin
            if (step == 5'd0)      out_addr = CMD_TIME;
            else                   out_addr = TIME_BASE + step_a - ONE_A;
         end
         S_WR_TIME: begin
            out_wr = 1'b1;
            if (step < NT5)        out_addr = TIME_BASE + step_a;
            else                   out_addr = CMD_TIME;
         end
         S_WR_TIMER: begin
            out_wr = 1'b1;
            if (step < NR5)        out_addr = TIMER_BASE + step_a;
            else                   out_addr = CMD_TIMER;
         end
         default: ;
      endcase
   end

   assign out_state = state;
   assign out_step  = step;

endmodule

// File: tb/tb_rtc_seq_ctrl_param.sv
// tb_rtc_seq_ctrl_param
//   Directed bench for the RTC sequencer with default register counts
//   (7 time regs, 3 timer regs). A list-based reference model tracks the
//   expected state/step and is compared against every output each cycle.
//   Directed literal checks pin the model. The watchdog section is built only
//   when RTC_SEQ_WDT_EN is defined, and then it uses a 16-cycle limit.
module tb_rtc_seq_ctrl_param;

`ifdef RTC_SEQ_WDT_EN
   localparam int TB_WDT = 16;
   localparam bit WDT_ON = 1'b1;
`else
   localparam int TB_WDT = 1024;
   localparam bit WDT_ON = 1'b0;
`endif
   localparam int NT = 7;
   localparam int NR = 3;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       reset_count;
   logic       in_done;
   logic [2:0] in_mode;
   logic [7:0] out_addr;
   logic [7:0] out_data_init;
   logic       out_init;
   logic       out_wr;
   logic       out_en;
   logic [2:0] out_state;
   logic [4:0] out_step;
   logic       out_timeout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rtc_seq_ctrl_param #(
      .ADDR_W(8), .DATA_W(8), .NUM_TIME_REGS(NT), .NUM_TIMER_REGS(NR),
      .TIME_BASE(8'h21), .TIMER_BASE(8'h41), .CMD_RD(8'hF0),
      .CMD_TIME(8'hF1), .CMD_TIMER(8'hF2), .WDT_CYCLES(TB_WDT)
   ) dut (
      .clk(clk), .reset_count(reset_count), .in_done(in_done), .in_mode(in_mode),
      .out_addr(out_addr), .out_data_init(out_data_init), .out_init(out_init),
      .out_wr(out_wr), .out_en(out_en), .out_state(out_state), .out_step(out_step),
      .out_timeout(out_timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each state's address list is written out from the register map,
   // so the expected address is lst[state][step].
   logic [7:0] lst [8][32];
   int         lst_len [8];
   logic [7:0] init_data [4];

   task automatic push(input int s, input logic [7:0] a);
      lst[s][lst_len[s]] = a;
      lst_len[s]++;
   endtask

   initial begin
      for (int s = 0; s < 8; s++) begin
         lst_len[s] = 0;
         for (int i = 0; i < 32; i++) lst[s][i] = 8'h00;
      end
      push(1, 8'h02); push(1, 8'h02); push(1, 8'h10); push(1, 8'h00);
      init_data[0] = 8'h10; init_data[1] = 8'h00; init_data[2] = 8'hD2; init_data[3] = 8'h00;
      push(2, 8'hF0);
      for (int i = 0; i < NT; i++) push(2, 8'h21 + 8'(i));
      for (int i = 0; i < NR; i++) push(2, 8'h41 + 8'(i));
      push(3, 8'hF2);
      for (int i = 0; i < NR; i++) push(3, 8'h41 + 8'(i));
      push(4, 8'hF1);
      for (int i = 0; i < 3; i++) push(4, 8'h21 + 8'(i));
      push(4, 8'hF2);
      for (int i = 0; i < NR; i++) push(4, 8'h41 + 8'(i));
      push(5, 8'hF1);
      for (int i = 0; i < NT; i++) push(5, 8'h21 + 8'(i));
      for (int i = 0; i < NT; i++) push(6, 8'h21 + 8'(i));
      push(6, 8'hF1);
      for (int i = 0; i < NR; i++) push(7, 8'h41 + 8'(i));
      push(7, 8'hF2);
   end

   function automatic int next_of(input int s, input logic [2:0] m);
      case (s)
         1: return 2;
         2: return (m == 3'b001) ? 3 : (m == 3'b010) ? 4 : (m == 3'b100) ? 5 : 2;
         3, 4: return (m == 3'b000) ? 6 : s;
         5: return (m == 3'b000) ? 7 : 5;
         default: return 2;
      endcase
   endfunction

   int m_state, m_step, m_wdt, m_ns, m_nstep;
   bit m_timeout;

   always @(posedge clk or posedge reset_count) begin
      if (reset_count) begin
         m_state = 0; m_step = 0; m_wdt = 0; m_timeout = 0;
      end else begin
         m_timeout = 0;
         m_ns = m_state; m_nstep = m_step;
         if (m_state == 0) begin
            m_ns = 1; m_nstep = 0;
         end else if (in_done) begin
            if (m_step == lst_len[m_state] - 1) begin
               m_ns = next_of(m_state, in_mode); m_nstep = 0;
            end else begin
               m_nstep = m_step + 1;
            end
         end
         if (WDT_ON && m_state != 0 && !in_done && m_wdt + 1 == TB_WDT) begin
            m_ns = 0; m_nstep = 0; m_timeout = 1; m_wdt = 0;
         end else if (m_state == 0 || in_done || m_ns != m_state) begin
            m_wdt = 0;
         end else begin
            m_wdt++;
         end
         m_state = m_ns; m_step = m_nstep;
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(posedge clk) begin
      #2;
      chk("cmp_state", 32'(out_state), 32'(m_state));
      chk("cmp_step",  32'(out_step),  32'(m_step));
      chk("cmp_en",    32'(out_en),    32'(m_state != 0));
      chk("cmp_addr",  32'(out_addr),  (m_state == 0) ? 32'h0 : 32'(lst[m_state][m_step]));
      chk("cmp_wr",    32'(out_wr),    32'(m_state == 1 || m_state == 6 || m_state == 7));
      chk("cmp_init",  32'(out_init),  32'(m_state == 1));
      chk("cmp_data",  32'(out_data_init), (m_state == 1) ? 32'(init_data[m_step & 3]) : 32'h0);
      chk("cmp_timeout", 32'(out_timeout), 32'(m_timeout));
   end

   // ---------------- driver tasks ----------------
   task automatic done_pulse();
      in_done = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
   endtask

   task automatic dones(input int n);
      for (int i = 0; i < n; i++) done_pulse();
   endtask

   task automatic lit(input string nm, input logic [2:0] s, input logic [4:0] st,
                      input logic [7:0] a, input logic w);
      chk({nm, "_state"}, 32'(out_state), 32'(s));
      chk({nm, "_step"},  32'(out_step),  32'(st));
      chk({nm, "_addr"},  32'(out_addr),  32'(a));
      chk({nm, "_wr"},    32'(out_wr),    32'(w));
   endtask

   task automatic all_zero(input string nm);
      chk({nm, "_vec"}, {out_addr, out_data_init, out_init, out_wr, out_en,
                         out_state, out_step, out_timeout}, 32'h0);
   endtask

   // ---------------- directed stimulus ----------------
   logic [7:0] rd_tab [11];
   int         to_at;

   initial begin
      rd_tab = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
      reset_count = 1'b1;
      in_done     = 1'b0;
      in_mode     = 3'b000;
      repeat (3) @(negedge clk);
      all_zero("reset");

      // 1: release -> IDLE one cycle -> INIT list
      reset_count = 1'b0;
      #1;
      chk("idle_state", 32'(out_state), 32'd0);
      chk("idle_en", 32'(out_en), 32'd0);
      @(negedge clk);
      lit("init0", 3'd1, 5'd0, 8'h02, 1'b1);
      chk("init0_data", 32'(out_data_init), 32'h10);
      chk("init0_init", 32'(out_init), 32'd1);
      done_pulse();
      lit("init1", 3'd1, 5'd1, 8'h02, 1'b1);
      chk("init1_data", 32'(out_data_init), 32'h00);
      done_pulse();
      lit("init2", 3'd1, 5'd2, 8'h10, 1'b1);
      chk("init2_data", 32'(out_data_init), 32'hD2);
      done_pulse();
      lit("init3", 3'd1, 5'd3, 8'h00, 1'b1);
      done_pulse();
      lit("rd_entry", 3'd2, 5'd0, 8'hF0, 1'b0);
      chk("rd_entry_init", 32'(out_init), 32'd0);

      // 2: full RD_CTE list with mode 000 repeats RD_CTE
      for (int i = 0; i < 11; i++) begin
         lit("rd_walk", 3'd2, 5'(i), rd_tab[i], 1'b0);
         done_pulse();
      end
      lit("rd_again", 3'd2, 5'd0, 8'hF0, 1'b0);

      // 3: mode 100 -> CFG_TIMER, then mode 000 -> WR_TIMER -> RD_CTE
      dones(10);
      in_mode = 3'b100;
      done_pulse();
      lit("cfg_timer0", 3'd5, 5'd0, 8'hF1, 1'b0);
      done_pulse();
      lit("cfg_timer1", 3'd5, 5'd1, 8'h21, 1'b0);
      in_mode = 3'b000;
      dones(7);
      lit("wr_timer0", 3'd7, 5'd0, 8'h41, 1'b1);
      done_pulse();
      lit("wr_timer1", 3'd7, 5'd1, 8'h42, 1'b1);
      done_pulse();
      lit("wr_timer2", 3'd7, 5'd2, 8'h43, 1'b1);
      done_pulse();
      lit("wr_timer3", 3'd7, 5'd3, 8'hF2, 1'b1);
      done_pulse();
      lit("wr_timer_back", 3'd2, 5'd0, 8'hF0, 1'b0);

      // 4: multi-hot ignored; mode change mid-CFG_DATE has no effect
      in_mode = 3'b011;
      dones(11);
      lit("multihot", 3'd2, 5'd0, 8'hF0, 1'b0);
      in_mode = 3'b010;
      dones(11);
      lit("cfg_date0", 3'd4, 5'd0, 8'hF1, 1'b0);
      dones(2);
      lit("cfg_date2", 3'd4, 5'd2, 8'h22, 1'b0);
      in_mode = 3'b001;
      dones(2);
      lit("cfg_date4", 3'd4, 5'd4, 8'hF2, 1'b0);
      dones(4);
      lit("cfg_date_rep", 3'd4, 5'd0, 8'hF1, 1'b0);
      in_mode = 3'b000;
      dones(8);
      lit("wr_time0", 3'd6, 5'd0, 8'h21, 1'b1);

      // 5: reset mid-WR_TIME at step 3
      dones(3);
      lit("wr_time3", 3'd6, 5'd3, 8'h24, 1'b1);
      reset_count = 1'b1;
      #1;
      all_zero("mid_reset");
      repeat (2) @(negedge clk);
      reset_count = 1'b0;
      #1;
      chk("post_rst_idle", 32'(out_state), 32'd0);
      @(negedge clk);
      lit("post_rst_init", 3'd1, 5'd0, 8'h02, 1'b1);

`ifdef RTC_SEQ_WDT_EN
      // 6: withhold done in RD_CTE until the watchdog fires
      dones(4);
      lit("wdt_rd", 3'd2, 5'd0, 8'hF0, 1'b0);
      to_at = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_timeout && to_at < 0) begin
            to_at = k;
            chk("wdt_idle", 32'(out_state), 32'd0);
         end
         if (k == 17) chk("wdt_reinit", 32'(out_state), 32'd1);
      end
      chk("wdt_cycle", 32'(to_at), 32'd16);
`else
      to_at = 0;
      repeat (40) @(negedge clk);
      chk("no_wdt_hold", 32'(out_state), 32'd1);
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
